// File: rtl/icache_fill.sv
// Icache line refill engine: one miss -> one memory line read -> four data-array
// beat writes (yielding to hit reads) -> one tag write -> done pulse.
module icache_fill #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TAG_WIDTH  = 20,
  parameter int unsigned BEATS      = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  miss2fill_valid,
  output logic                  miss2fill_ready,
  input  logic [ADDR_WIDTH-1:0] miss2fill_addr,
  input  logic [2:0]            miss2fill_way,
  output logic                  fill2miss_done,
  output logic                  fill2mem_req_valid,
  input  logic                  fill2mem_req_ready,
  output logic [ADDR_WIDTH-1:0] fill2mem_req_addr,
  input  logic                  mem2fill_rvalid,
  output logic                  mem2fill_rready,
  input  logic [127:0]          mem2fill_rdata,
  input  logic                  mem2fill_rlast,
  input  logic                  hit_read2data_array_valid,
  output logic                  fill2data_array_valid,
  output logic [5:0]            fill2data_array_index,
  output logic [2:0]            fill2data_array_way,
  output logic [1:0]            fill2data_array_offset,
  output logic [127:0]          fill2data_array_wdata,
  output logic                  fill2tag_array_valid,
  output logic [5:0]            fill2tag_array_index,
  output logic [2:0]            fill2tag_array_way,
  output logic [TAG_WIDTH-1:0]  fill2tag_array_tag,
  output logic                  fill_err
);

  localparam int unsigned DATA_W  = 128;
  localparam int unsigned IDX_W   = 6;
  localparam int unsigned WAY_W   = 3;
  localparam int unsigned OFF_W   = 2;
  localparam int unsigned LINE_LO = 6;
  localparam int unsigned TAG_LO  = 12;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(BEATS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_RECV,
    S_TAG,
    S_DONE
  } state_t;

  state_t               r_state;
  logic [IDX_W-1:0]     r_index;
  logic [TAG_WIDTH-1:0] r_tag;
  logic [WAY_W-1:0]     r_way;
  logic [OFF_W-1:0]     r_cnt;
  logic                 r_buf_valid;
  logic [DATA_W-1:0]    r_buf_data;
  logic                 r_err;
  logic                 r_miss_ready;
  logic                 r_req_valid;
  logic                 r_tag_valid;
  logic                 r_done;

  logic                 w_in_recv;
  logic                 w_wr_fire;
  logic                 w_rready;
  logic                 w_capture;
  logic [OFF_W-1:0]     w_cap_idx;
  logic                 w_unused_addr;

  // Line offset bits of the miss address play no part in a whole-line refill.
  assign w_unused_addr = ^miss2fill_addr[LINE_LO-1:0];

  // Beat buffer drains only when hit_read leaves the data array free.
  assign w_in_recv = (r_state == S_RECV);
  assign w_wr_fire = w_in_recv && r_buf_valid && !hit_read2data_array_valid;
  assign w_rready  = w_in_recv && (!r_buf_valid || w_wr_fire);
  assign w_capture = mem2fill_rvalid && w_rready;
  // Line position of the beat being captured: one ahead if the buffer is draining.
  assign w_cap_idx = r_cnt + OFF_W'(r_buf_valid);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_index      <= '0;
      r_tag        <= '0;
      r_way        <= '0;
      r_cnt        <= '0;
      r_buf_valid  <= 1'b0;
      r_buf_data   <= '0;
      r_err        <= 1'b0;
      r_miss_ready <= 1'b1;
      r_req_valid  <= 1'b0;
      r_tag_valid  <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_tag_valid <= 1'b0;
      r_done      <= 1'b0;

      if (w_capture) begin
        r_buf_data <= mem2fill_rdata;
        if (mem2fill_rlast != (w_cap_idx == LAST_BEAT)) begin
          r_err <= 1'b1;
        end
      end

      unique case (r_state)
        S_IDLE: begin
          if (miss2fill_valid) begin
            r_index      <= miss2fill_addr[TAG_LO-1:LINE_LO];
            r_tag        <= TAG_WIDTH'(miss2fill_addr[ADDR_WIDTH-1:TAG_LO]);
            r_way        <= miss2fill_way;
            r_cnt        <= '0;
            r_miss_ready <= 1'b0;
            r_req_valid  <= 1'b1;
            r_state      <= S_REQ;
          end
        end
        S_REQ: begin
          if (fill2mem_req_ready) begin
            r_req_valid <= 1'b0;
            r_state     <= S_RECV;
          end
        end
        S_RECV: begin
          if (w_capture) begin
            r_buf_valid <= 1'b1;
          end else if (w_wr_fire) begin
            r_buf_valid <= 1'b0;
          end
          // Completion is counted on writes, never inferred from rlast.
          if (w_wr_fire) begin
            r_cnt <= r_cnt + OFF_W'(1);
            if (r_cnt == LAST_BEAT) begin
              r_tag_valid <= 1'b1;
              r_state     <= S_TAG;
            end
          end
        end
        S_TAG: begin
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_miss_ready <= 1'b1;
          r_state      <= S_IDLE;
        end
        default: begin
          r_miss_ready <= 1'b1;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

  assign miss2fill_ready        = r_miss_ready;
  assign fill2mem_req_valid     = r_req_valid;
  assign fill2mem_req_addr      = ADDR_WIDTH'({r_tag, r_index, {LINE_LO{1'b0}}});
  assign mem2fill_rready        = w_rready;
  assign fill2data_array_valid  = w_wr_fire;
  assign fill2data_array_index  = r_index;
  assign fill2data_array_way    = r_way;
  assign fill2data_array_offset = r_cnt;
  assign fill2data_array_wdata  = r_buf_data;
  assign fill2tag_array_valid   = r_tag_valid;
  assign fill2tag_array_index   = r_index;
  assign fill2tag_array_way     = r_way;
  assign fill2tag_array_tag     = r_tag;
  assign fill2miss_done         = r_done;
  assign fill_err               = r_err;

endmodule
